// File: rtl/anb_rd_arb_mux.sv
// N-to-1 ANB read arbiter/mux: one address grant at a time toward the memory
// controller, with an ID queue that routes in-order read data back to the requester.
module anb_rd_arb_mux #(
    parameter int N           = 4,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 16,
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 32,
    parameter int MAX_OUTST   = 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*ADDR_W-1:0]   m_addr,
    input  logic [N*LEN_W-1:0]    m_len,
    input  logic [N-1:0]          m_avalid,
    output logic [N-1:0]          m_aready,
    output logic [N*DATA_W-1:0]   m_data,
    output logic [N-1:0]          m_last,
    output logic [N-1:0]          m_valid,
    input  logic [N-1:0]          m_ready,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [LEN_W-1:0]      s_len,
    output logic                  s_avalid,
    input  logic                  s_aready,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  orphan_err
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int PW  = $clog2(DEPTH);
    // With no per-master limit, the queue depth bounds each counter instead.
    localparam int CW  = (MAX_OUTST > 0) ? $clog2(MAX_OUTST + 1) : $clog2(DEPTH + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      aid_q, aid_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [LEN_W-1:0]    s_len_q, s_len_d;
    logic                s_avalid_q, s_avalid_d;
    logic                orphan_q;

    logic [IDW-1:0]      idq_q [DEPTH];
    logic [PW:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]         q_count;
    logic                q_full, q_empty;
    logic [IDW-1:0]      head;
    logic                push, pop;

    logic [CW-1:0]       outst_q [N];
    logic [N-1:0]        elig, inc, dec;
    logic [ADDR_W-1:0]   m_addr_a [N];
    logic [LEN_W-1:0]    m_len_a [N];
    logic [IDW-1:0]      win, cand;
    logic                any_elig;

    assign q_count = wr_ptr_q - rd_ptr_q;
    assign q_full  = (q_count == (PW+1)'(DEPTH));
    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign head    = idq_q[rd_ptr_q[PW-1:0]];
    assign s_ready = !q_empty && m_ready[head];
    assign pop     = s_valid && s_ready && s_last;
    assign push    = (state_q == ST_GRANT) && s_aready;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_port
            assign m_addr_a[gi] = m_addr[gi*ADDR_W +: ADDR_W];
            assign m_len_a[gi]  = m_len[gi*LEN_W +: LEN_W];
            assign elig[gi]     = m_avalid[gi] && !q_full &&
                                  ((MAX_OUTST == 0) || (outst_q[gi] < CW'(MAX_OUTST)));
            assign m_aready[gi] = (state_q == ST_GRANT) && (aid_q == IDW'(gi)) && s_aready;
            assign m_data[gi*DATA_W +: DATA_W] = s_data;
            assign m_valid[gi]  = !q_empty && (head == IDW'(gi)) && s_valid;
            assign m_last[gi]   = !q_empty && (head == IDW'(gi)) && s_last;
            assign inc[gi]      = push && (aid_q == IDW'(gi));
            assign dec[gi]      = pop && (head == IDW'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    outst_q[gi] <= '0;
                end else if (inc[gi] && !dec[gi]) begin
                    outst_q[gi] <= outst_q[gi] + 1'b1;
                end else if (dec[gi] && !inc[gi]) begin
                    outst_q[gi] <= outst_q[gi] - 1'b1;
                end
            end
        end
    endgenerate

    // Scan from the far end so the candidate closest to the start point is kept last.
    always_comb begin
        win      = '0;
        cand     = '0;
        any_elig = |elig;
        for (int k = N - 1; k >= 0; k--) begin
            if (ROUND_ROBIN != 0) begin
                cand = IDW'((int'(ptr_q) + k) % N);
            end else begin
                cand = IDW'(k);
            end
            if (elig[cand]) begin
                win = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        aid_d      = aid_q;
        ptr_d      = ptr_q;
        s_addr_d   = s_addr_q;
        s_len_d    = s_len_q;
        s_avalid_d = s_avalid_q;
        case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    aid_d      = win;
                    s_addr_d   = m_addr_a[win];
                    s_len_d    = m_len_a[win];
                    s_avalid_d = 1'b1;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (s_aready) begin
                    s_avalid_d = 1'b0;
                    ptr_d      = (aid_q == IDW'(N - 1)) ? '0 : aid_q + 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            aid_q      <= '0;
            ptr_q      <= '0;
            s_addr_q   <= '0;
            s_len_q    <= '0;
            s_avalid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            orphan_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            aid_q      <= aid_d;
            ptr_q      <= ptr_d;
            s_addr_q   <= s_addr_d;
            s_len_q    <= s_len_d;
            s_avalid_q <= s_avalid_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (s_valid && q_empty) begin
                orphan_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            idq_q[wr_ptr_q[PW-1:0]] <= aid_q;
        end
    end

    assign s_addr     = s_addr_q;
    assign s_len      = s_len_q;
    assign s_avalid   = s_avalid_q;
    assign orphan_err = orphan_q;

endmodule

// File: tb/tb_anb_rd_arb_mux.sv
// Directed bench: a round-robin instance with a 2-request limit and a
// fixed-priority instance with a 4-entry queue, both driven by the same stimulus.
module tb_anb_rd_arb_mux;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N*AW-1:0]   m_addr;
    logic [N*LW-1:0]   m_len;
    logic [N-1:0]      m_avalid, m_ready;
    logic              s_aready, s_valid, s_last;
    logic [DW-1:0]     s_data;

    logic [N-1:0]      rr_m_aready, rr_m_last, rr_m_valid;
    logic [N*DW-1:0]   rr_m_data;
    logic [AW-1:0]     rr_s_addr;
    logic [LW-1:0]     rr_s_len;
    logic              rr_s_avalid, rr_s_ready, rr_orphan;

    logic [N-1:0]      pr_m_aready, pr_m_last, pr_m_valid;
    logic [N*DW-1:0]   pr_m_data;
    logic [AW-1:0]     pr_s_addr;
    logic [LW-1:0]     pr_s_len;
    logic              pr_s_avalid, pr_s_ready, pr_orphan;

    int n_cmp = 0;
    int n_err = 0;

    anb_rd_arb_mux #(.N(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .DEPTH(16),
                     .MAX_OUTST(2), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rst(rst), .m_addr(m_addr), .m_len(m_len), .m_avalid(m_avalid),
        .m_aready(rr_m_aready), .m_data(rr_m_data), .m_last(rr_m_last),
        .m_valid(rr_m_valid), .m_ready(m_ready), .s_addr(rr_s_addr), .s_len(rr_s_len),
        .s_avalid(rr_s_avalid), .s_aready(s_aready), .s_data(s_data), .s_last(s_last),
        .s_valid(s_valid), .s_ready(rr_s_ready), .orphan_err(rr_orphan));

    anb_rd_arb_mux #(.N(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .DEPTH(4),
                     .MAX_OUTST(0), .ROUND_ROBIN(0)) u_pr (
        .clk(clk), .rst(rst), .m_addr(m_addr), .m_len(m_len), .m_avalid(m_avalid),
        .m_aready(pr_m_aready), .m_data(pr_m_data), .m_last(pr_m_last),
        .m_valid(pr_m_valid), .m_ready(m_ready), .s_addr(pr_s_addr), .s_len(pr_s_len),
        .s_avalid(pr_s_avalid), .s_aready(s_aready), .s_data(s_data), .s_last(s_last),
        .s_valid(s_valid), .s_ready(pr_s_ready), .orphan_err(pr_orphan));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_avalid = '0;
        m_ready  = '0;
        s_aready = 1'b0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        s_data   = '0;
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW] = 32'(32'h100 * (i + 1));
            m_len[i*LW +: LW]  = 16'(i + 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        m_avalid = 4'hF;
        m_ready  = 4'hF;
        s_aready = 1'b1;
        s_valid  = 1'b1;
        cyc();
        cyc();
        n_cmp++; if (rr_s_avalid !== 1'b0) begin n_err++; $display("FAIL reset_s_avalid got %b want 0", rr_s_avalid); end
        n_cmp++; if (rr_m_aready !== 4'b0000) begin n_err++; $display("FAIL reset_m_aready got %b want 0000", rr_m_aready); end
        n_cmp++; if (rr_m_valid !== 4'b0000) begin n_err++; $display("FAIL reset_m_valid got %b want 0000", rr_m_valid); end
        n_cmp++; if (rr_m_last !== 4'b0000) begin n_err++; $display("FAIL reset_m_last got %b want 0000", rr_m_last); end
        n_cmp++; if (rr_s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready got %b want 0", rr_s_ready); end
        n_cmp++; if (rr_orphan !== 1'b0) begin n_err++; $display("FAIL reset_orphan got %b want 0", rr_orphan); end
        n_cmp++; if (pr_s_avalid !== 1'b0) begin n_err++; $display("FAIL reset_pr_s_avalid got %b want 0", pr_s_avalid); end
        $display("reset: outputs checked under active inputs");
    endtask

    task automatic test_single();
        logic [3:0] exp_last;
        do_reset();
        m_addr[2*AW +: AW] = 32'h1000;
        m_len[2*LW +: LW]  = 16'd4;
        m_avalid = 4'b0100;
        s_aready = 1'b1;
        #1;
        n_cmp++; if (rr_s_avalid !== 1'b0) begin n_err++; $display("FAIL single_pre_avalid got %b want 0", rr_s_avalid); end
        cyc();
        n_cmp++; if (rr_s_avalid !== 1'b1) begin n_err++; $display("FAIL single_avalid got %b want 1", rr_s_avalid); end
        n_cmp++; if (rr_s_addr !== 32'h1000) begin n_err++; $display("FAIL single_addr got %h want 00001000", rr_s_addr); end
        n_cmp++; if (rr_s_len !== 16'd4) begin n_err++; $display("FAIL single_len got %0d want 4", rr_s_len); end
        n_cmp++; if (rr_m_aready !== 4'b0100) begin n_err++; $display("FAIL single_aready got %b want 0100", rr_m_aready); end
        cyc();
        m_avalid = 4'b0000;
        #1;
        n_cmp++; if (rr_s_avalid !== 1'b0) begin n_err++; $display("FAIL single_avalid_drop got %b want 0", rr_s_avalid); end
        cyc();
        n_cmp++; if (rr_m_aready !== 4'b0000) begin n_err++; $display("FAIL single_aready_once got %b want 0000", rr_m_aready); end
        m_ready = 4'hF;
        for (int b = 1; b <= 4; b++) begin
            s_valid  = 1'b1;
            s_last   = (b == 4);
            s_data   = 64'(64'hD0 + b);
            exp_last = (b == 4) ? 4'b0100 : 4'b0000;
            #1;
            n_cmp++; if (rr_m_valid !== 4'b0100) begin n_err++; $display("FAIL single_valid beat %0d got %b want 0100", b, rr_m_valid); end
            n_cmp++; if (rr_m_last !== exp_last) begin n_err++; $display("FAIL single_last beat %0d got %b want %b", b, rr_m_last, exp_last); end
            n_cmp++; if (rr_m_data !== {4{s_data}}) begin n_err++; $display("FAIL single_data beat %0d got %h want %h", b, rr_m_data, {4{s_data}}); end
            n_cmp++; if (rr_s_ready !== 1'b1) begin n_err++; $display("FAIL single_s_ready beat %0d got %b want 1", b, rr_s_ready); end
            cyc();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        n_cmp++; if (rr_s_ready !== 1'b0) begin n_err++; $display("FAIL single_empty_after got s_ready %b want 0", rr_s_ready); end
        $display("single: m2 addr 1000 len 4 granted, 4 beats routed to m2");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        int m;
        do_reset();
        m_avalid = 4'hF;
        s_aready = 1'b1;
        for (int g = 0; g < 8; g++) begin
            cyc();
            m = g % 4;
            exp_rdy = 4'(1 << m);
            n_cmp++; if (rr_m_aready !== exp_rdy) begin n_err++; $display("FAIL rr_grant %0d got %b want %b", g, rr_m_aready, exp_rdy); end
            n_cmp++; if (rr_s_addr !== 32'(32'h100 * (m + 1))) begin n_err++; $display("FAIL rr_addr %0d got %h want %h", g, rr_s_addr, 32'(32'h100 * (m + 1))); end
            if (g < 4) begin
                n_cmp++; if (pr_m_aready !== 4'b0001) begin n_err++; $display("FAIL prio_grant %0d got %b want 0001", g, pr_m_aready); end
            end else begin
                n_cmp++; if (pr_s_avalid !== 1'b0) begin n_err++; $display("FAIL prio_full %0d got s_avalid %b want 0", g, pr_s_avalid); end
            end
            $display("rr: grant %0d rr=%b prio=%b", g, rr_m_aready, pr_m_aready);
            cyc();
        end
        cyc();
        cyc();
        n_cmp++; if (rr_s_avalid !== 1'b0) begin n_err++; $display("FAIL rr_all_at_limit got s_avalid %b want 0", rr_s_avalid); end
    endtask

    task automatic test_outstanding();
        do_reset();
        m_avalid = 4'b0001;
        s_aready = 1'b1;
        cyc();
        n_cmp++; if (rr_m_aready !== 4'b0001) begin n_err++; $display("FAIL outst_grant1 got %b want 0001", rr_m_aready); end
        cyc();
        cyc();
        n_cmp++; if (rr_m_aready !== 4'b0001) begin n_err++; $display("FAIL outst_grant2 got %b want 0001", rr_m_aready); end
        cyc();
        for (int c = 0; c < 4; c++) begin
            cyc();
            n_cmp++; if (rr_m_aready !== 4'b0000) begin n_err++; $display("FAIL outst_blocked cycle %0d got %b want 0000", c, rr_m_aready); end
        end
        s_valid = 1'b1;
        s_last  = 1'b1;
        m_ready = 4'b0001;
        #1;
        n_cmp++; if (rr_m_valid !== 4'b0001) begin n_err++; $display("FAIL outst_resp_valid got %b want 0001", rr_m_valid); end
        cyc();
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        n_cmp++; if (rr_m_aready !== 4'b0000) begin n_err++; $display("FAIL outst_not_yet got %b want 0000", rr_m_aready); end
        cyc();
        n_cmp++; if (rr_m_aready !== 4'b0001) begin n_err++; $display("FAIL outst_grant3 got %b want 0001", rr_m_aready); end
        $display("outstanding: third request granted after first response");
    endtask

    task automatic test_queue_full();
        do_reset();
        m_avalid = 4'b0010;
        s_aready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            cyc();
            n_cmp++; if (pr_m_aready !== 4'b0010) begin n_err++; $display("FAIL qfull_grant %0d got %b want 0010", g, pr_m_aready); end
            cyc();
        end
        cyc();
        cyc();
        n_cmp++; if (pr_s_avalid !== 1'b0) begin n_err++; $display("FAIL qfull_no_grant got %b want 0", pr_s_avalid); end
        s_aready = 1'b0;
        s_valid  = 1'b1;
        s_last   = 1'b1;
        m_ready  = 4'b0010;
        #1;
        n_cmp++; if (pr_m_valid !== 4'b0010) begin n_err++; $display("FAIL qfull_resp got %b want 0010", pr_m_valid); end
        cyc();
        s_valid = 1'b0;
        s_last  = 1'b0;
        cyc();
        n_cmp++; if (pr_s_avalid !== 1'b1) begin n_err++; $display("FAIL qfull_regrant got %b want 1", pr_s_avalid); end
        s_aready = 1'b1;
        s_valid  = 1'b1;
        s_last   = 1'b1;
        #1;
        n_cmp++; if ({pr_m_aready, pr_s_ready} !== 5'b00101) begin n_err++; $display("FAIL qfull_push_pop got %b want 00101", {pr_m_aready, pr_s_ready}); end
        cyc();
        s_valid = 1'b0;
        s_last  = 1'b0;
        cyc();
        n_cmp++; if (pr_s_avalid !== 1'b1) begin n_err++; $display("FAIL qfull_refill got %b want 1", pr_s_avalid); end
        cyc();
        cyc();
        cyc();
        n_cmp++; if (pr_s_avalid !== 1'b0) begin n_err++; $display("FAIL qfull_full_again got %b want 0", pr_s_avalid); end
        m_avalid = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            s_valid = 1'b1;
            s_last  = 1'b1;
            #1;
            n_cmp++; if (pr_m_valid !== 4'b0010) begin n_err++; $display("FAIL qfull_drain %0d got %b want 0010", b, pr_m_valid); end
            cyc();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        n_cmp++; if (pr_s_ready !== 1'b0) begin n_err++; $display("FAIL qfull_empty got s_ready %b want 0", pr_s_ready); end
        $display("queue_full: 4 entries, push+pop, refill to 4, drained 4");
    endtask

    task automatic test_back_to_back();
        do_reset();
        m_avalid = 4'b1010;
        s_aready = 1'b1;
        cyc();
        n_cmp++; if (rr_m_aready !== 4'b0010) begin n_err++; $display("FAIL order_grant_m1 got %b want 0010", rr_m_aready); end
        cyc();
        m_avalid = 4'b1000;
        cyc();
        n_cmp++; if (rr_m_aready !== 4'b1000) begin n_err++; $display("FAIL order_grant_m3 got %b want 1000", rr_m_aready); end
        cyc();
        m_avalid = 4'b0000;
        m_ready  = 4'b1000;
        s_valid  = 1'b1;
        s_last   = 1'b0;
        s_data   = 64'hA1;
        #1;
        n_cmp++; if ({rr_s_ready, rr_m_valid} !== 5'b00010) begin n_err++; $display("FAIL order_stall got %b want 00010", {rr_s_ready, rr_m_valid}); end
        cyc();
        cyc();
        n_cmp++; if ({rr_s_ready, rr_m_valid[3]} !== 2'b00) begin n_err++; $display("FAIL order_stall_hold got %b want 00", {rr_s_ready, rr_m_valid[3]}); end
        m_ready = 4'b1010;
        #1;
        n_cmp++; if (rr_s_ready !== 1'b1) begin n_err++; $display("FAIL order_release got %b want 1", rr_s_ready); end
        cyc();
        s_last = 1'b1;
        #1;
        n_cmp++; if (rr_m_last !== 4'b0010) begin n_err++; $display("FAIL order_m1_last got %b want 0010", rr_m_last); end
        cyc();
        s_last = 1'b0;
        #1;
        n_cmp++; if ({rr_s_ready, rr_m_valid} !== 5'b11000) begin n_err++; $display("FAIL order_m3_head got %b want 11000", {rr_s_ready, rr_m_valid}); end
        cyc();
        s_last = 1'b1;
        cyc();
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        n_cmp++; if (rr_s_ready !== 1'b0) begin n_err++; $display("FAIL order_empty got %b want 0", rr_s_ready); end
        $display("back_to_back: m1 then m3, m1 backpressure held m3");
    endtask

    task automatic test_orphan_reset();
        int grants;
        do_reset();
        m_ready = 4'hF;
        s_valid = 1'b1;
        #1;
        n_cmp++; if ({rr_orphan, rr_s_ready, rr_m_valid} !== 6'b000000) begin n_err++; $display("FAIL orphan_pre got %b want 000000", {rr_orphan, rr_s_ready, rr_m_valid}); end
        cyc();
        n_cmp++; if (rr_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_set got %b want 1", rr_orphan); end
        s_valid = 1'b0;
        cyc();
        n_cmp++; if (rr_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_sticky got %b want 1", rr_orphan); end
        m_avalid = 4'b0001;
        s_aready = 1'b1;
        cyc();
        cyc();
        m_avalid = 4'b0010;
        s_aready = 1'b0;
        cyc();
        s_valid = 1'b1;
        s_last  = 1'b0;
        #1;
        n_cmp++; if ({rr_s_avalid, rr_m_valid} !== 5'b10001) begin n_err++; $display("FAIL orphan_midburst got %b want 10001", {rr_s_avalid, rr_m_valid}); end
        rst     = 1'b1;
        s_valid = 1'b0;
        cyc();
        n_cmp++; if ({rr_orphan, rr_s_avalid, rr_s_ready, rr_m_aready} !== 7'b0000000) begin n_err++; $display("FAIL rst_mid got %b want 0000000", {rr_orphan, rr_s_avalid, rr_s_ready, rr_m_aready}); end
        rst      = 1'b0;
        m_avalid = 4'b0001;
        s_aready = 1'b1;
        grants   = 0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (rr_m_aready[0]) grants++;
        end
        n_cmp++; if (grants !== 2) begin n_err++; $display("FAIL rst_counters got %0d grants want 2", grants); end
        $display("orphan_reset: sticky flag set, mid-burst reset cleared state");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_outstanding();
        test_queue_full();
        test_back_to_back();
        test_orphan_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
